fpu_in_dispatch: RTL and testbench
==================================

# fpu_in_dispatch

Input-side dispatcher of the FPU: accepts FP operation packets arriving from the PCX, buffers them in an in-order FIFO, and issues each to the add, multiply or divide pipe when that pipe can accept it. Sits between the PCX interface and the three FPU pipes, mirroring the output arbiter that returns results to the CPX. Returns one credit to the PCX per consumed packet so the sender never overruns the buffer. Carries the same 10-bit operation ID used on the return path: [9:2] CPX request, [1:0] thread.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- PTRW, log2(DEPTH), pointer width (derived)

- rclk  in  1  clock, all state updates on rising edge
- arst  in  1  asynchronous active-high reset
- pcx_fpio_vld  in  1  packet valid this cycle
- pcx_fpio_type  in  2  00 add, 01 mul, 10 div, 11 illegal
- pcx_fpio_id  in  10  operation ID
- add_stall  in  1  add pipe cannot accept this cycle
- mul_stall  in  1  mul pipe cannot accept this cycle
- div_rdy  in  1  div pipe idle and can accept this cycle
- add_issue  out  1  head issued to add pipe this cycle
- mul_issue  out  1  head issued to mul pipe this cycle
- div_issue  out  1  head issued to div pipe this cycle
- issue_id  out  10  ID of issued op; 0 when no issue
- fpio_pcx_credit  out  1  one-cycle credit pulse, registered
- illegal_drop  out  1  one-cycle pulse, registered; illegal head discarded
- ovf_err  out  1  sticky; packet arrived with FIFO full and no dequeue
- fifo_cnt  out  PTRW+1  current occupancy

## Operation
- Storage: DEPTH entries of {type[1:0], id[9:0]}; wr_ptr, rd_ptr wrap modulo DEPTH; cnt 0..DEPTH.
- Enqueue: pcx_fpio_vld && (cnt < DEPTH || deq) writes entry at wr_ptr, wr_ptr++.
- Overflow: pcx_fpio_vld && cnt == DEPTH && !deq drops packet, sets ovf_err (cleared only by arst); pointers, cnt unchanged.
- Head valid when cnt != 0. Strict in-order: head blocks all younger entries (no bypass around a stalled pipe).
- Issue (combinational from head and pipe inputs):
  - type 00: add_issue = head_vld && !add_stall
  - type 01: mul_issue = head_vld && !mul_stall
  - type 10: div_issue = head_vld && div_rdy
  - type 11: no issue; head discarded unconditionally
- deq = add_issue | mul_issue | div_issue | (head_vld && type==11); rd_ptr++ on deq.
- cnt_next = cnt + enq - deq; enq and deq same cycle leaves cnt unchanged, including at cnt == DEPTH.
- issue_id = head id when any issue, else 10'h000. At most one issue signal high per cycle.
- fpio_pcx_credit registered from deq; illegal_drop registered from (head_vld && type==11).
- Stall/rdy inputs evaluated only for the head's type; others ignored.

## Timing
- Reset: pointers, cnt, fpio_pcx_credit, illegal_drop, ovf_err = 0; issue outputs 0 since FIFO empty. Asynchronous assertion takes effect immediately; in-flight entries discarded, no credits returned for them.
- Packet valid in cycle N: written at end of N; earliest issue cycle N+1 (no same-cycle flow-through).
- Issue in cycle M: pipe samples op at end of M; credit pulse in M+1.
- Back-to-back: unstalled add/mul sustain one issue per cycle.
- Full FIFO with issue in cycle M: packet in M accepted, no ovf_err.
- Wrap: pointers roll DEPTH-1 -> 0 with no bubble.

## Test plan
- Reset, then packet add id=10'h155 in cycle 1, stalls low -> add_issue=1, issue_id=10'h155 in cycle 2; credit=1 in cycle 3; fifo_cnt back to 0.
- add_stall=1 for 5 cycles with head add followed by a mul -> neither issues for 5 cycles; add issues in cycle after stall drops, mul next cycle; two credits in order.
- div head with div_rdy=0 for 10 cycles, then 1 -> div_issue exactly once; DEPTH=4 fill while blocked, fifo_cnt=4.
- FIFO full, no dequeue, extra packet -> ovf_err=1 and stays 1; fifo_cnt=4; entries issue unaltered after unblock; simultaneous full+issue+new packet -> accepted, ovf_err stays 0.
- type 11 head -> no issue, illegal_drop and credit pulse one cycle later; next entry issues following cycle.
- 20 packets round-robin types, random stalls, arst mid-stream -> all outputs 0 immediately, fifo_cnt=0, post-reset traffic correct; IDs issue in arrival order across pointer wrap.

Source files
------------

// File: rtl/fpu_in_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : fpu_in_dispatch
// Description : FPU input dispatcher. Buffers PCX operation packets in an
//               in-order FIFO and issues the head to the add, mul or div pipe
//               when that pipe can take it. Illegal-type heads are dropped.
//               Every consumed packet returns one registered credit to PCX.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_in_dispatch #(
    parameter int DEPTH = 4,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic            rclk,
    input  logic            arst,
    input  logic            pcx_fpio_vld,
    input  logic [1:0]      pcx_fpio_type,
    input  logic [9:0]      pcx_fpio_id,
    input  logic            add_stall,
    input  logic            mul_stall,
    input  logic            div_rdy,
    output logic            add_issue,
    output logic            mul_issue,
    output logic            div_issue,
    output logic [9:0]      issue_id,
    output logic            fpio_pcx_credit,
    output logic            illegal_drop,
    output logic            ovf_err,
    output logic [PTRW:0]   fifo_cnt
);

    localparam logic [1:0]      c_type_add = 2'b00;
    localparam logic [1:0]      c_type_mul = 2'b01;
    localparam logic [1:0]      c_type_div = 2'b10;
    localparam logic [PTRW:0]   c_full     = (PTRW+1)'(DEPTH);
    localparam logic [PTRW:0]   c_cnt_one  = (PTRW+1)'(1);
    localparam logic [PTRW-1:0] c_ptr_one  = PTRW'(1);

    // Each entry is {type[1:0], id[9:0]}
    logic [11:0]     r_mem [DEPTH];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [PTRW:0]   r_cnt;
    logic            r_credit;
    logic            r_illegal;
    logic            r_ovf;

    logic            w_head_vld;
    logic [1:0]      w_head_type;
    logic [9:0]      w_head_id;
    logic            w_add;
    logic            w_mul;
    logic            w_div;
    logic            w_drop;
    logic            w_deq;
    logic            w_enq;
    logic            w_ovf;

    assign w_head_vld  = (r_cnt != '0);
    assign w_head_type = r_mem[r_rd_ptr][11:10];
    assign w_head_id   = r_mem[r_rd_ptr][9:0];

    // Issue decision: only the head's own pipe condition is consulted
    always_comb begin
        w_add  = 1'b0;
        w_mul  = 1'b0;
        w_div  = 1'b0;
        w_drop = 1'b0;
        if (w_head_vld) begin
            case (w_head_type)
                c_type_add: w_add  = !add_stall;
                c_type_mul: w_mul  = !mul_stall;
                c_type_div: w_div  = div_rdy;
                default:    w_drop = 1'b1;
            endcase
        end
    end

    // A dequeue in the same cycle frees the slot, so a full FIFO can still accept
    assign w_deq = w_add | w_mul | w_div | w_drop;
    assign w_enq = pcx_fpio_vld && ((r_cnt < c_full) || w_deq);
    assign w_ovf = pcx_fpio_vld && (r_cnt == c_full) && !w_deq;

    // Storage array; no reset needed since occupancy gates every read
    always_ff @(posedge rclk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= {pcx_fpio_type, pcx_fpio_id};
        end
    end

    // Pointers, occupancy and registered status pulses
    always_ff @(posedge rclk or posedge arst) begin
        if (arst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_cnt     <= '0;
            r_credit  <= 1'b0;
            r_illegal <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_enq, w_deq})
                2'b10:   r_cnt <= r_cnt + c_cnt_one;
                2'b01:   r_cnt <= r_cnt - c_cnt_one;
                default: r_cnt <= r_cnt;
            endcase
            r_credit  <= w_deq;
            r_illegal <= w_drop;
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign add_issue       = w_add;
    assign mul_issue       = w_mul;
    assign div_issue       = w_div;
    assign issue_id        = (w_add | w_mul | w_div) ? w_head_id : 10'h000;
    assign fpio_pcx_credit = r_credit;
    assign illegal_drop    = r_illegal;
    assign ovf_err         = r_ovf;
    assign fifo_cnt        = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fpu_in_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_in_dispatch
// Description : Self-checking bench for fpu_in_dispatch. A queue-based model
//               is compared against the DUT every cycle; directed sequences
//               add literal expectations, then random traffic with a
//               mid-stream asynchronous reset exercises pointer wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_in_dispatch;

    localparam int DEPTH = 4;
    localparam int PTRW  = 2;

    logic          rclk = 1'b0;
    logic          arst;
    logic          pcx_fpio_vld;
    logic [1:0]    pcx_fpio_type;
    logic [9:0]    pcx_fpio_id;
    logic          add_stall;
    logic          mul_stall;
    logic          div_rdy;
    logic          add_issue;
    logic          mul_issue;
    logic          div_issue;
    logic [9:0]    issue_id;
    logic          fpio_pcx_credit;
    logic          illegal_drop;
    logic          ovf_err;
    logic [PTRW:0] fifo_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 rclk = ~rclk;

    fpu_in_dispatch #(.DEPTH(DEPTH)) dut (
        .rclk            (rclk),
        .arst            (arst),
        .pcx_fpio_vld    (pcx_fpio_vld),
        .pcx_fpio_type   (pcx_fpio_type),
        .pcx_fpio_id     (pcx_fpio_id),
        .add_stall       (add_stall),
        .mul_stall       (mul_stall),
        .div_rdy         (div_rdy),
        .add_issue       (add_issue),
        .mul_issue       (mul_issue),
        .div_issue       (div_issue),
        .issue_id        (issue_id),
        .fpio_pcx_credit (fpio_pcx_credit),
        .illegal_drop    (illegal_drop),
        .ovf_err         (ovf_err),
        .fifo_cnt        (fifo_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain queue of {type,id}, sticky overflow flag and
    // the one-cycle-delayed credit / drop pulses.
    logic [11:0] mq[$];
    bit          m_ovf;
    bit          m_credit;
    bit          m_drop;

    always @(negedge rclk) begin
        bit         hv;
        bit         e_add;
        bit         e_mul;
        bit         e_div;
        bit         e_drop;
        bit         deq;
        logic [9:0] e_id;
        int         sz;
        if (arst) begin
            chk("rst_outputs",
                {add_issue, mul_issue, div_issue, issue_id, fpio_pcx_credit,
                 illegal_drop, ovf_err, fifo_cnt}, 0);
            mq.delete();
            m_ovf    = 0;
            m_credit = 0;
            m_drop   = 0;
        end else begin
            sz     = mq.size();
            hv     = (sz != 0);
            e_add  = 0;
            e_mul  = 0;
            e_div  = 0;
            e_drop = 0;
            e_id   = 10'h000;
            if (hv) begin
                case (mq[0][11:10])
                    2'd0:    e_add  = !add_stall;
                    2'd1:    e_mul  = !mul_stall;
                    2'd2:    e_div  = div_rdy;
                    default: e_drop = 1;
                endcase
            end
            if (e_add || e_mul || e_div) e_id = mq[0][9:0];
            deq = e_add | e_mul | e_div | e_drop;

            chk("m_add_issue", add_issue, e_add);
            chk("m_mul_issue", mul_issue, e_mul);
            chk("m_div_issue", div_issue, e_div);
            chk("m_issue_id", issue_id, e_id);
            chk("m_credit", fpio_pcx_credit, m_credit);
            chk("m_illegal_drop", illegal_drop, m_drop);
            chk("m_ovf_err", ovf_err, m_ovf);
            chk("m_fifo_cnt", fifo_cnt, sz);

            m_credit = deq;
            m_drop   = e_drop;
            if (deq) void'(mq.pop_front());
            if (pcx_fpio_vld) begin
                if (sz < DEPTH || deq) mq.push_back({pcx_fpio_type, pcx_fpio_id});
                else                   m_ovf = 1;
            end
        end
    end

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic push(input logic [1:0] t, input logic [9:0] i);
        pcx_fpio_vld  = 1'b1;
        pcx_fpio_type = t;
        pcx_fpio_id   = i;
    endtask

    task automatic idle();
        pcx_fpio_vld = 1'b0;
    endtask

    initial begin
        int next_id;
        arst          = 1'b1;
        pcx_fpio_vld  = 1'b0;
        pcx_fpio_type = 2'd0;
        pcx_fpio_id   = 10'h000;
        add_stall     = 1'b0;
        mul_stall     = 1'b0;
        div_rdy       = 1'b0;
        repeat (2) @(posedge rclk);
        #1;
        chk("reset_cnt", fifo_cnt, 0);
        chk("reset_ovf", ovf_err, 0);
        chk("reset_credit", fpio_pcx_credit, 0);
        arst = 1'b0;

        // Single add, no stalls
        step(); push(2'd0, 10'h155);
        step(); idle();
        @(negedge rclk);
        chk("t1_add_issue", add_issue, 1);
        chk("t1_issue_id", issue_id, 10'h155);
        step();
        @(negedge rclk);
        chk("t1_credit", fpio_pcx_credit, 1);
        chk("t1_cnt", fifo_cnt, 0);

        // Add stalled with a mul behind it
        step(); add_stall = 1'b1; push(2'd0, 10'h011);
        step(); push(2'd1, 10'h022);
        step(); idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge rclk);
            chk("t2_blocked", {add_issue, mul_issue}, 0);
            step();
        end
        add_stall = 1'b0;
        @(negedge rclk);
        chk("t2_add_id", {add_issue, issue_id}, {1'b1, 10'h011});
        step();
        @(negedge rclk);
        chk("t2_mul_id", {mul_issue, issue_id}, {1'b1, 10'h022});
        chk("t2_credit1", fpio_pcx_credit, 1);
        step();
        @(negedge rclk);
        chk("t2_credit2", fpio_pcx_credit, 1);

        // Div head blocked for 10 cycles while the FIFO fills
        step(); div_rdy = 1'b0; push(2'd2, 10'h033);
        step(); push(2'd0, 10'h034);
        step(); push(2'd0, 10'h035);
        step(); push(2'd0, 10'h036);
        step(); idle();
        for (int k = 0; k < 10; k++) begin
            @(negedge rclk);
            chk("t3_div_blocked", div_issue, 0);
            step();
        end
        @(negedge rclk);
        chk("t3_full_cnt", fifo_cnt, 4);
        step(); div_rdy = 1'b1;
        @(negedge rclk);
        chk("t3_div_id", {div_issue, issue_id}, {1'b1, 10'h033});
        step(); div_rdy = 1'b0;
        @(negedge rclk);
        chk("t3_next_add", {add_issue, div_issue, issue_id}, {2'b10, 10'h034});
        repeat (3) step();

        // Full FIFO, issue and new packet in the same cycle
        push(2'd2, 10'h040);
        step(); push(2'd0, 10'h041);
        step(); push(2'd0, 10'h042);
        step(); push(2'd0, 10'h043);
        step(); div_rdy = 1'b1; push(2'd0, 10'h044);
        step(); idle(); div_rdy = 1'b0;
        @(negedge rclk);
        chk("t4_no_ovf", ovf_err, 0);
        chk("t4_cnt", fifo_cnt, 4);
        chk("t4_add_id", {add_issue, issue_id}, {1'b1, 10'h041});
        repeat (5) step();

        // Overflow: full, blocked, extra packet
        push(2'd2, 10'h050);
        step(); push(2'd0, 10'h051);
        step(); push(2'd0, 10'h052);
        step(); push(2'd0, 10'h053);
        step(); push(2'd0, 10'h0FF);
        step(); idle();
        @(negedge rclk);
        chk("t5_ovf", ovf_err, 1);
        chk("t5_cnt", fifo_cnt, 4);
        step(); div_rdy = 1'b1;
        @(negedge rclk);
        chk("t5_id0", {div_issue, issue_id}, {1'b1, 10'h050});
        step(); div_rdy = 1'b0;
        @(negedge rclk);
        chk("t5_id1", issue_id, 10'h051);
        step();
        @(negedge rclk);
        chk("t5_id2", issue_id, 10'h052);
        step();
        @(negedge rclk);
        chk("t5_id3", issue_id, 10'h053);
        step();
        @(negedge rclk);
        chk("t5_ovf_sticky", ovf_err, 1);
        chk("t5_cnt_empty", fifo_cnt, 0);

        // Illegal head dropped, next entry issues right after
        step(); push(2'd3, 10'h077);
        step(); push(2'd0, 10'h078);
        @(negedge rclk);
        chk("t6_no_issue", {add_issue, mul_issue, div_issue, issue_id}, 0);
        step(); idle();
        @(negedge rclk);
        chk("t6_drop", {illegal_drop, fpio_pcx_credit}, 2'b11);
        chk("t6_add_id", {add_issue, issue_id}, {1'b1, 10'h078});
        step();
        @(negedge rclk);
        chk("t6_drop_clear", illegal_drop, 0);

        // Random traffic with an asynchronous reset mid-stream
        next_id = 1;
        for (int cyc = 0; cyc < 300; cyc++) begin
            step();
            if (cyc == 40) begin
                #2;
                arst = 1'b1;
                #1;
                chk("t7_async_rst",
                    {add_issue, mul_issue, div_issue, issue_id, fpio_pcx_credit,
                     illegal_drop, ovf_err, fifo_cnt}, 0);
                idle();
                step();
                step();
                arst = 1'b0;
            end
            pcx_fpio_vld  = ($urandom_range(99) < 60);
            pcx_fpio_type = ($urandom_range(15) == 0) ? 2'd3 : 2'(next_id % 3);
            pcx_fpio_id   = 10'(next_id);
            if (pcx_fpio_vld) next_id++;
            add_stall     = ($urandom_range(99) < 30);
            mul_stall     = ($urandom_range(99) < 30);
            div_rdy       = ($urandom_range(99) < 40);
        end
        step();
        idle();
        add_stall = 1'b0;
        mul_stall = 1'b0;
        div_rdy   = 1'b1;
        repeat (10) step();
        @(negedge rclk);
        chk("t7_drained", fifo_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
